// File: rtl/sha256_pkg.sv
// sha256_pkg: hash-core register map, command values and
// loader state encoding shared by the message-loader slice.
package sha256_pkg;

  localparam logic [6:0] W_MEM_BASE  = 7'd0;
  localparam logic [6:0] W_MEM_LAST  = W_MEM_BASE + 7'd63;
  localparam logic [6:0] WHO_AM_I    = 7'd64;
  localparam logic [6:0] STATUS      = 7'd65;
  localparam logic [6:0] DIGEST_BASE = 7'd70;
  localparam logic [6:0] DIGEST_LAST = DIGEST_BASE + 7'd31;

  localparam logic [7:0] START_CMD = 8'h01;
  localparam logic [7:0] PAD_MARK  = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_PAD,
    ST_START,
    ST_WAIT,
    ST_READ
  } loader_state_t;

  // Message byte k lands at the top of W_MEM, walking down.
  function automatic logic [6:0] w_addr(logic [5:0] k);
    return W_MEM_LAST - {1'b0, k};
  endfunction

  // Digest byte j is read from the top of the digest window.
  function automatic logic [6:0] d_addr(logic [4:0] j);
    return DIGEST_LAST - {2'b0, j};
  endfunction

endpackage

// File: rtl/sha256_msg_loader_if.sv
// sha256_msg_loader_if: message stream in, hash-core bus,
// digest stream out. master = loader side, slave = environment.
interface sha256_msg_loader_if;

  logic [7:0] i_s_data;
  logic       i_s_valid;
  logic       i_s_last;
  logic       o_s_ready;

  logic [6:0] o_h_addr;
  logic [7:0] o_h_data;
  logic       o_h_we;
  logic       i_h_irq;
  logic [7:0] i_h_rdata;

  logic [7:0] o_m_data;
  logic       o_m_valid;
  logic       o_m_last;
  logic       i_m_ready;

  modport master (
    input  i_s_data, i_s_valid, i_s_last,
    output o_s_ready,
    output o_h_addr, o_h_data, o_h_we,
    input  i_h_irq, i_h_rdata,
    output o_m_data, o_m_valid, o_m_last,
    input  i_m_ready
  );

  modport slave (
    output i_s_data, i_s_valid, i_s_last,
    input  o_s_ready,
    input  o_h_addr, o_h_data, o_h_we,
    output i_h_irq, i_h_rdata,
    input  o_m_data, o_m_valid, o_m_last,
    output i_m_ready
  );

endinterface

// File: rtl/sha256_msg_loader.sv
// sha256_msg_loader: loads a <=55-byte message into a SHA-256 core,
// pads it, starts the core, waits for irq and streams the digest.
// Ports: i_clk, i_rst (async, high), bus (master), o_err, o_busy.
module sha256_msg_loader
  import sha256_pkg::*;
#(
  parameter int IRQ_TIMEOUT = 1023
) (
  input  logic                i_clk,
  input  logic                i_rst,
  sha256_msg_loader_if.master bus,
  output logic                o_err,
  output logic                o_busy
);

  localparam int MAX_MSG_BYTES = 55;
  localparam int WCW = $clog2(IRQ_TIMEOUT + 1);
  localparam logic [5:0] N_MAX = 6'(MAX_MSG_BYTES);
  localparam logic [WCW-1:0] W_END = WCW'(IRQ_TIMEOUT - 1);

  loader_state_t  st;
  logic [5:0]     n;
  logic [5:0]     p;
  logic [4:0]     j;
  logic [WCW-1:0] wcnt;

  logic        s_rdy;
  logic        s_acc;
  logic        m_acc;
  logic        fits;
  logic        to_hit;
  logic [15:0] bit_len;

  assign s_rdy = (st == ST_IDLE) | (st == ST_LOAD)
               | (st == ST_DRAIN);
  // Gated by reset so nothing is written while i_rst is high.
  assign s_acc = s_rdy & bus.i_s_valid & ~i_rst;
  assign m_acc = (st == ST_READ) & bus.i_m_ready;
  // Byte k=n being accepted still fits if n+1 <= 55.
  assign fits = n < N_MAX;
  assign to_hit = wcnt == W_END;
  assign bit_len = {7'd0, n, 3'd0};
  assign o_busy = st != ST_IDLE;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      st   <= ST_IDLE;
      n    <= '0;
      p    <= '0;
      j    <= '0;
      wcnt <= '0;
    end else begin
      unique case (st)
        ST_IDLE, ST_LOAD: begin
          if (s_acc) begin
            n <= n + 6'd1;
            p <= n + 6'd1;
            if (bus.i_s_last && !fits) begin
              st <= ST_IDLE;
              n  <= '0;
              p  <= '0;
            end else if (bus.i_s_last) begin
              st <= ST_PAD;
            end else if (n == N_MAX) begin
              st <= ST_DRAIN;
            end else begin
              st <= ST_LOAD;
            end
          end
        end
        ST_DRAIN: begin
          if (s_acc && bus.i_s_last) begin
            st <= ST_IDLE;
            n  <= '0;
            p  <= '0;
          end
        end
        ST_PAD: begin
          if (p == 6'd63) st <= ST_START;
          else p <= p + 6'd1;
        end
        ST_START: begin
          st   <= ST_WAIT;
          wcnt <= '0;
          n    <= '0;
          p    <= '0;
        end
        ST_WAIT: begin
          if (bus.i_h_irq) begin
            st   <= ST_READ;
            j    <= '0;
            wcnt <= '0;
          end else if (to_hit) begin
            st   <= ST_IDLE;
            wcnt <= '0;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        ST_READ: begin
          if (m_acc) begin
            j <= j + 5'd1;
            if (j == 5'd31) st <= ST_IDLE;
          end
        end
        default: st <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.o_s_ready = s_rdy;
    bus.o_h_we    = 1'b0;
    bus.o_h_addr  = WHO_AM_I;
    bus.o_h_data  = '0;
    bus.o_m_data  = '0;
    bus.o_m_valid = 1'b0;
    bus.o_m_last  = 1'b0;
    o_err         = 1'b0;
    unique case (st)
      ST_IDLE, ST_LOAD: begin
        if (s_acc) begin
          bus.o_h_we   = 1'b1;
          bus.o_h_addr = w_addr(n);
          bus.o_h_data = bus.i_s_data;
          o_err        = bus.i_s_last & ~fits;
        end
      end
      ST_DRAIN: begin
        o_err = s_acc & bus.i_s_last;
      end
      ST_PAD: begin
        bus.o_h_we   = 1'b1;
        bus.o_h_addr = w_addr(p);
        unique case (1'b1)
          (p == n):     bus.o_h_data = PAD_MARK;
          (p == 6'd62): bus.o_h_data = bit_len[15:8];
          (p == 6'd63): bus.o_h_data = bit_len[7:0];
          default:      bus.o_h_data = 8'h00;
        endcase
      end
      ST_START: begin
        bus.o_h_we   = 1'b1;
        bus.o_h_addr = STATUS;
        bus.o_h_data = START_CMD;
      end
      ST_WAIT: begin
        o_err = ~bus.i_h_irq & to_hit;
      end
      ST_READ: begin
        bus.o_h_addr  = d_addr(j);
        bus.o_m_data  = bus.i_h_rdata;
        bus.o_m_valid = 1'b1;
        bus.o_m_last  = j == 5'd31;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha256_msg_loader.sv
// tb_sha256_msg_loader: directed vectors for the message loader
// against a small hash-core register file model.
module tb_sha256_msg_loader;
  import sha256_pkg::*;

  logic i_clk;
  logic i_rst;
  logic o_err;
  logic o_busy;

  sha256_msg_loader_if bus ();

  sha256_msg_loader #(.IRQ_TIMEOUT(1023)) u_dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .bus    (bus),
    .o_err  (o_err),
    .o_busy (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  localparam logic [20:0] RST_VEC =
    {1'b1, 1'b0, 7'd64, 8'd0, 4'b0000};

  logic [255:0] dig =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  logic [7:0] mem [0:127];
  logic [7:0] msg [0:63];
  logic       clr = 1'b0;
  int starts = 0;
  int err_st = 0;
  int errs = 0;
  int n_vec = 0;
  int n_bad = 0;
  int ok, cyc, at, s0, e0;
  bit seen;

  assign bus.i_h_rdata = mem[bus.o_h_addr];

  always @(posedge i_clk) begin
    if (clr) begin
      for (int a = 0; a < 128; a++) begin
        if (a >= int'(DIGEST_BASE) && a <= int'(DIGEST_LAST))
          mem[a] <= dig[8*(a-int'(DIGEST_BASE)) +: 8];
        else
          mem[a] <= 8'hEE;
      end
    end else if (bus.o_h_we) begin
      mem[bus.o_h_addr] <= bus.o_h_data;
    end
    if (bus.o_h_we && bus.o_h_addr == STATUS) begin
      starts <= starts + 1;
      if (o_err) err_st <= err_st + 1;
    end
    if (o_err) errs <= errs + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [20:0] out_vec();
    return {bus.o_s_ready, bus.o_h_we, bus.o_h_addr, bus.o_h_data,
            bus.o_m_valid, bus.o_m_last, o_err, o_busy};
  endfunction

  task automatic clear_mem();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic set_abc();
    msg[0] = 8'h61;
    msg[1] = 8'h62;
    msg[2] = 8'h63;
  endtask

  task automatic send_msg(input int len, output int good);
    good = 0;
    for (int k = 0; k < len; k++) begin
      bus.i_s_valid = 1'b1;
      bus.i_s_data  = msg[k];
      bus.i_s_last  = (k == len - 1);
      #1;
      if (k < 56) begin
        if (bus.o_s_ready && bus.o_h_we &&
            bus.o_h_addr == 7'(63 - k) && bus.o_h_data == msg[k])
          good++;
      end else if (bus.o_s_ready && !bus.o_h_we) begin
        good++;
      end
      tick();
    end
    bus.i_s_valid = 1'b0;
    bus.i_s_last  = 1'b0;
    bus.i_s_data  = 8'h00;
  endtask

  task automatic run_to_start(input int irq_at, output int c_at,
                              output bit found);
    int bad;
    bad = 0;
    found = 1'b0;
    c_at = -1;
    for (int c = 0; c < 100 && !found; c++) begin
      bus.i_h_irq = (c == irq_at);
      #1;
      if (bus.o_h_we && bus.o_h_addr == STATUS) begin
        found = 1'b1;
        c_at = c;
        chk("start_data", 32'(bus.o_h_data), 'h01);
        chk("start_no_err", 32'(o_err), 0);
      end else if (bus.o_s_ready || bus.o_m_valid || !bus.o_h_we) begin
        bad++;
      end
      tick();
    end
    bus.i_h_irq = 1'b0;
    chk("pad_ctrl", bad, 0);
  endtask

  task automatic check_image(input int len);
    int bad;
    logic [7:0] e;
    logic [15:0] bl;
    bad = 0;
    bl = 16'(len * 8);
    for (int k = 0; k < 64; k++) begin
      if (k < len) e = msg[k];
      else if (k == len) e = 8'h80;
      else if (k == 62) e = bl[15:8];
      else if (k == 63) e = bl[7:0];
      else e = 8'h00;
      if (mem[int'(W_MEM_BASE) + 63 - k] !== e) bad++;
    end
    chk("w_image", bad, 0);
  endtask

  task automatic wait_irq(input int dly);
    int bad;
    bad = 0;
    for (int d = 0; d < dly; d++) begin
      #1;
      if (!o_busy || bus.o_m_valid || bus.o_h_we || o_err) bad++;
      tick();
    end
    bus.i_h_irq = 1'b1;
    #1;
    if (bus.o_m_valid) bad++;
    tick();
    bus.i_h_irq = 1'b0;
    chk("wait_quiet", bad, 0);
  endtask

  task automatic read_digest(input bit toggle);
    int got, good, stl;
    logic [6:0] pa;
    logic [7:0] pd;
    bit pst;
    got = 0; good = 0; stl = 0; pst = 1'b0;
    pa = '0; pd = '0;
    for (int c = 0; c < 200 && got < 32; c++) begin
      bus.i_m_ready = toggle ? c[0] : 1'b1;
      #1;
      if (pst && (bus.o_h_addr != pa || bus.o_m_data != pd)) stl++;
      if (bus.o_m_valid && bus.i_m_ready) begin
        if (bus.o_m_data == dig[255-8*got -: 8] &&
            bus.o_h_addr == 7'(101 - got) &&
            bus.o_m_last == (got == 31))
          good++;
        got++;
      end
      pst = bus.o_m_valid && !bus.i_m_ready;
      pa = bus.o_h_addr;
      pd = bus.o_m_data;
      tick();
    end
    bus.i_m_ready = 1'b0;
    chk("rd_count", got, 32);
    chk("rd_bytes", good, 32);
    if (toggle) chk("rd_stall", stl, 0);
    #1;
    chk("rd_idle", 32'({o_busy, bus.o_m_valid}), 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b1;
    bus.i_s_valid = 1'b0;
    bus.i_s_last  = 1'b0;
    bus.i_s_data  = 8'h00;
    bus.i_h_irq   = 1'b0;
    bus.i_m_ready = 1'b0;
    #2;
    chk("rst_outs", 32'(out_vec()), 32'(RST_VEC));
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    clear_mem();

    bus.i_h_irq = 1'b1;
    tick();
    bus.i_h_irq = 1'b0;
    #1;
    chk("irq_idle", 32'(o_busy), 0);
    tick();

    // "abc", irq pulse inside PAD must be ignored
    set_abc();
    send_msg(3, ok);
    chk("abc_load", ok, 3);
    run_to_start(20, cyc, seen);
    chk("abc_start", 32'(seen), 1);
    chk("abc_lat", cyc, 61);
    chk("abc_m63", 32'(mem[63]), 'h61);
    chk("abc_m61", 32'(mem[61]), 'h63);
    chk("abc_m60", 32'(mem[60]), 'h80);
    chk("abc_m1", 32'(mem[1]), 'h00);
    chk("abc_m0", 32'(mem[0]), 'h18);
    check_image(3);
    wait_irq(5);
    read_digest(1'b1);

    // 55-byte message, then irq timeout
    clear_mem();
    s0 = starts;
    e0 = errs;
    for (int k = 0; k < 55; k++) msg[k] = 8'(k + 1);
    send_msg(55, ok);
    chk("m55_load", ok, 55);
    run_to_start(-1, cyc, seen);
    chk("m55_start", 32'(seen), 1);
    chk("m55_lat", cyc, 9);
    chk("m55_m8", 32'(mem[8]), 'h80);
    chk("m55_m1", 32'(mem[1]), 'h01);
    chk("m55_m0", 32'(mem[0]), 'hB8);
    check_image(55);
    at = -1;
    for (int c = 1; c <= 1100 && at < 0; c++) begin
      #1;
      if (o_err) at = c;
      tick();
    end
    chk("to_cycle", at, 1023);
    #1;
    chk("to_busy", 32'(o_busy), 0);
    tick();
    chk("to_errs", errs - e0, 1);
    chk("m55_starts", starts - s0, 1);

    // 56 bytes: error on the last byte, no start
    s0 = starts;
    e0 = errs;
    for (int k = 0; k < 57; k++) msg[k] = 8'(8'hA0 + k);
    send_msg(56, ok);
    chk("m56_load", ok, 56);
    for (int c = 0; c < 10; c++) tick();
    chk("m56_err", errs - e0, 1);
    chk("m56_nostart", starts - s0, 0);
    #1;
    chk("m56_busy", 32'(o_busy), 0);
    tick();

    // 57 bytes: extra byte drained, error on last
    send_msg(57, ok);
    chk("m57_load", ok, 57);
    for (int c = 0; c < 10; c++) tick();
    chk("m57_err", errs - e0, 2);
    chk("m57_nostart", starts - s0, 0);

    // reset during PAD, with a byte offered
    clear_mem();
    set_abc();
    send_msg(3, ok);
    for (int c = 0; c < 5; c++) tick();
    s0 = starts;
    i_rst = 1'b1;
    bus.i_s_valid = 1'b1;
    bus.i_s_data  = 8'h55;
    #1;
    chk("rst_pad", 32'(out_vec()), 32'(RST_VEC));
    tick();
    bus.i_s_valid = 1'b0;
    bus.i_s_data  = 8'h00;
    tick();
    i_rst = 1'b0;
    for (int c = 0; c < 70; c++) tick();
    chk("rst_pad_nostart", starts - s0, 0);

    // reset during WAIT
    clear_mem();
    send_msg(3, ok);
    run_to_start(-1, cyc, seen);
    chk("w_start", 32'(seen), 1);
    for (int c = 0; c < 3; c++) tick();
    i_rst = 1'b1;
    #1;
    chk("rst_wait", 32'(out_vec()), 32'(RST_VEC));
    tick();
    i_rst = 1'b0;
    tick();

    // clean "abc" after the resets
    clear_mem();
    send_msg(3, ok);
    chk("abc2_load", ok, 3);
    run_to_start(-1, cyc, seen);
    chk("abc2_start", 32'(seen), 1);
    check_image(3);
    wait_irq(2);
    read_digest(1'b0);
    chk("err_with_start", err_st, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/sha256_msg_loader.md
SHA256_MSG_LOADER -- requirements
Module: sha256_msg_loader

Interface
REQ-001 Parameter: IRQ_TIMEOUT, 1023, WAIT-state cycle limit before error.
REQ-002 Parameter: MAX_MSG_BYTES, 55, largest single-block message in bytes; fixed, not for override.
REQ-003 Port: i_clk  in  1  sole clock, rising edge.
REQ-004 Port: i_rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: i_s_data  in  8  message byte.
REQ-006 Port: i_s_valid  in  1  message byte valid.
REQ-007 Port: i_s_last  in  1  final message byte.
REQ-008 Port: o_s_ready  out  1  loader accepts a byte.
REQ-009 Port: o_h_addr  out  7  hash-core register address.
REQ-010 Port: o_h_data  out  8  hash-core write data.
REQ-011 Port: o_h_we  out  1  hash-core write strobe.
REQ-012 Port: i_h_irq  in  1  hash-core completion pulse.
REQ-013 Port: i_h_rdata  in  8  hash-core combinational read data for o_h_addr.
REQ-014 Port: o_m_data  out  8  digest byte.
REQ-015 Port: o_m_valid  out  1  digest byte valid.
REQ-016 Port: o_m_last  out  1  digest byte 31.
REQ-017 Port: i_m_ready  in  1  digest consumer ready.
REQ-018 Port: o_err  out  1  one-cycle error pulse.
REQ-019 Port: o_busy  out  1  high in every state except IDLE.

Function
REQ-020 States: IDLE, LOAD, DRAIN, PAD, START, WAIT, READ.
REQ-021 IDLE: o_s_ready=1, o_h_we=0, o_h_addr=64; first accepted byte moves to LOAD.
REQ-022 LOAD: o_s_ready=1; each accepted byte k (0-based) is written in the same cycle, with o_h_we=1, o_h_addr=63-k, o_h_data=i_s_data.
REQ-023 Byte counter n is 6 bits and counts accepted bytes; accepting byte k=55 without i_s_last moves to DRAIN.
REQ-024 DRAIN: o_s_ready=1, no core writes; when the i_s_last byte is accepted, pulse o_err and return to IDLE; START is never issued.
REQ-025 Accepting an i_s_last byte with n+1<=55 moves to PAD; o_s_ready=0 from PAD through READ.
REQ-026 PAD writes one byte per cycle for k=n..63 at addr 63-k: k=n gives 0x80; n<k<=61 gives 0x00; k=62 gives L[15:8]; k=63 gives L[7:0], where L=n*8 is the 16-bit bit length.
REQ-027 START: a single write with o_h_addr=65 and o_h_data=0x01, then WAIT.
REQ-028 WAIT: the loader counts cycles; i_h_irq=1 moves to READ with digest index j=0; count reaching IRQ_TIMEOUT pulses o_err and returns to IDLE.
REQ-029 READ: o_h_addr=101-j, o_m_data=i_h_rdata (combinational), o_m_valid=1, o_m_last=(j==31).
REQ-030 READ: o_m_valid&i_m_ready increments j; the handshake at j=31 returns to IDLE.
REQ-031 READ: o_h_addr and o_m_data hold stable while i_m_ready=0; no timeout applies.
REQ-032 Maximum message (k=0..54 in LOAD, no extra bytes): PAD writes 9 bytes, then START; latency from the last byte to the START write is 64-n cycles.
REQ-033 i_h_irq outside WAIT is ignored.
REQ-034 o_err never asserts together with a core write to addr 65.

Reset
REQ-035 i_rst=1 forces IDLE asynchronously: o_s_ready=1, o_h_we=0, o_h_addr=64, o_h_data=0, o_m_valid=0, o_m_last=0, o_err=0, o_busy=0, all counters 0.
REQ-036 Reset mid-operation discards the message and any partial digest; no core write occurs while i_rst=1.

Structure
REQ-037 The shared package sha256_pkg holds the core address map (W_MEM 0..63, WHO_AM_I 64, STATUS 65, DIGEST 70..101), the START value 0x01, and the loader state encoding.
REQ-038 The block is a single module with no sub-module; PAD byte selection is inline logic.

Verification
REQ-039 "abc" (0x61,0x62,0x63, last on 0x63) -> writes addr63=0x61, 62=0x62, 61=0x63, 60=0x80, 59..2=0x00, 1=0x00, 0=0x18, then 65=0x01; with a real core the digest stream is 0xba,0x78,0x16,0xbf ... 0x15,0xad with o_m_last on 0xad.
REQ-040 55-byte message -> addr8=0x80, addr1=0x01, addr0=0xB8, START follows; 56-byte message -> one o_err pulse, no write to addr 65, back to IDLE.
REQ-041 i_m_ready toggled 1/0 every cycle during READ -> exactly 32 bytes delivered in order, addr/data stable across each stall.
REQ-042 i_h_irq held 0 -> o_err pulses at WAIT cycle 1023, then o_busy=0.
REQ-043 i_rst pulsed in WAIT and in PAD -> outputs at reset values immediately; the next "abc" completes correctly.
